// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions for the fetch stage: opcode constants, the
// opcode-class decode used to size instructions, condition-code bit
// positions and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

  // Load/store opcodes (2-byte: opcode + immediate/direct address)
  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;

  // ALU opcodes (1-byte) occupy a contiguous range
  localparam logic [7:0] OP_ALU_FIRST = 8'h42;
  localparam logic [7:0] OP_ALU_LAST  = 8'h4C;

  // Branch opcodes (2-byte: opcode + target). Low nibble selects condition.
  localparam logic [7:0] OP_BRA = 8'h20;
  localparam logic [7:0] OP_BMI = 8'h21;
  localparam logic [7:0] OP_BPL = 8'h22;
  localparam logic [7:0] OP_BEQ = 8'h23;
  localparam logic [7:0] OP_BNE = 8'h24;
  localparam logic [7:0] OP_BVS = 8'h25;
  localparam logic [7:0] OP_BVC = 8'h26;
  localparam logic [7:0] OP_BCS = 8'h27;
  localparam logic [7:0] OP_BCC = 8'h28;

  // ccr = {N,Z,V,C}
  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  typedef enum logic [1:0] {
    CLS_ALU,      // 1-byte
    CLS_MEM,      // 2-byte, issued
    CLS_BRANCH,   // 2-byte, resolved locally
    CLS_ILLEGAL   // treated as 1-byte, flagged
  } op_class_t;

  typedef enum logic [2:0] {
    FETCH_OP,
    LATCH_OP,
    FETCH_OPR,
    LATCH_OPR,
    BRANCH,
    ISSUE
  } fetch_state_t;

  function automatic op_class_t op_class(input logic [7:0] op);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    if (op >= OP_BRA && op <= OP_BCC)
      cls = CLS_BRANCH;
    else if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST)
      cls = CLS_ALU;
    else if (op == OP_LDA_IMM || op == OP_LDA_DIR || op == OP_LDB_IMM ||
             op == OP_LDB_DIR || op == OP_STA_DIR || op == OP_STB_DIR)
      cls = CLS_MEM;
    return cls;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_branch_cond.sv
// Branch condition evaluator: combinational map from the low nibble of a
// branch opcode and the execute-stage condition codes to a taken flag.
// Ports:
//   cond   in  4  opcode[3:0] of a branch (0=BRA .. 8=BCC)
//   ccr    in  4  {N,Z,V,C}
//   taken  out 1  branch taken
module instr_fetch_unit_branch_cond
  import instr_fetch_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] ccr,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      4'h0: taken = 1'b1;          // BRA
      4'h1: taken =  ccr[CCR_N];   // BMI
      4'h2: taken = ~ccr[CCR_N];   // BPL
      4'h3: taken =  ccr[CCR_Z];   // BEQ
      4'h4: taken = ~ccr[CCR_Z];   // BNE
      4'h5: taken =  ccr[CCR_V];   // BVS
      4'h6: taken = ~ccr[CCR_V];   // BVC
      4'h7: taken =  ccr[CCR_C];   // BCS
      4'h8: taken = ~ccr[CCR_C];   // BCC
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencer stage behind the synchronous program ROM.
// Owns the PC, absorbs the ROM's one-cycle read latency, assembles 1- and
// 2-byte instructions, resolves branches locally and issues everything else
// to the execute stage over valid/ready.
// Ports:
//   clk, reset      clock (shared with ROM), async active-high reset
//   rom_address     out 8  copy of pc
//   rom_data        in  8  ROM word for the address presented last cycle
//   ccr, ex_idle    in     execute-stage flags; ccr final when ex_idle=1
//   ins_valid/ready        issue handshake
//   opcode, operand, ins_pc  out  issued instruction (operand 0 for 1-byte)
//   illegal_op      out 1  one-cycle pulse when an undefined opcode is latched
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int         ROM_DEPTH = 128,
  parameter logic [7:0] RESET_PC  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  input  logic [3:0] ccr,
  input  logic       ex_idle,
  output logic       ins_valid,
  input  logic       ins_ready,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic [7:0] ins_pc,
  output logic       illegal_op
);

  // ROM_DEPTH is a power of two, so masking implements the modulo wrap and
  // keeps the unused high address bits at zero.
  localparam logic [7:0] PC_MASK = 8'(ROM_DEPTH - 1);

  fetch_state_t state;
  logic [7:0]   pc;
  logic [7:0]   pc_inc;
  op_class_t    rom_cls;
  logic         ir_is_branch;
  logic         taken;

  assign rom_address  = pc;
  assign pc_inc       = (pc + 8'd1) & PC_MASK;
  assign rom_cls      = op_class(rom_data);
  // opcode doubles as the IR; its class decides what follows the operand
  assign ir_is_branch = (op_class(opcode) == CLS_BRANCH);

  instr_fetch_unit_branch_cond u_branch_cond (
    .cond  (opcode[3:0]),
    .ccr   (ccr),
    .taken (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH_OP;
      pc         <= RESET_PC & PC_MASK;
      ins_valid  <= 1'b0;
      opcode     <= 8'h00;
      operand    <= 8'h00;
      ins_pc     <= 8'h00;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        // ROM registers the word at pc during this cycle
        FETCH_OP: state <= LATCH_OP;

        LATCH_OP: begin
          opcode <= rom_data;
          ins_pc <= pc;
          pc     <= pc_inc;
          if (rom_cls == CLS_MEM || rom_cls == CLS_BRANCH) begin
            state <= FETCH_OPR;
          end else begin
            operand    <= 8'h00;
            ins_valid  <= 1'b1;
            illegal_op <= (rom_cls == CLS_ILLEGAL);
            state      <= ISSUE;
          end
        end

        FETCH_OPR: state <= LATCH_OPR;

        LATCH_OPR: begin
          operand <= rom_data;
          pc      <= pc_inc;
          if (ir_is_branch) begin
            state <= BRANCH;
          end else begin
            ins_valid <= 1'b1;
            state     <= ISSUE;
          end
        end

        // ccr is only trusted once the execute stage has drained
        BRANCH: begin
          if (ex_idle) begin
            if (taken) pc <= operand & PC_MASK;
            state <= FETCH_OP;
          end
        end

        // outputs are frozen here until the transfer
        ISSUE: begin
          if (ins_ready) begin
            ins_valid <= 1'b0;
            state     <= FETCH_OP;
          end
        end

        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural 128x8 synchronous ROM,
// expected issues queued before each scenario and checked as they leave.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rom_address;
  logic [7:0] rom_data = 8'h00;
  logic [3:0] ccr = 4'h0;
  logic       ex_idle = 1'b1;
  logic       ins_valid;
  logic       ins_ready = 1'b1;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] ins_pc;
  logic       illegal_op;

  instr_fetch_unit #(.ROM_DEPTH(128), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (rst),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .ccr         (ccr),
    .ex_idle     (ex_idle),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .opcode      (opcode),
    .operand     (operand),
    .ins_pc      (ins_pc),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [128];
  always @(posedge clk) rom_data <= rom[rom_address[6:0]];

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] opr;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   ill_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one grid point = 1 time unit after a rising edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    #1;
    sb.delete();
    ill_cnt = 0;
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    step(2);
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] opr, input logic [7:0] pc);
    sb.push_back({op, opr, pc});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL %s_drain: observed pending=%0d expected pending=0", tag, sb.size());
    end
    sb.delete();
  endtask

  // issue monitor: every transfer must match the oldest queued expectation
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (illegal_op) ill_cnt++;
      if (ins_valid && ins_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL spurious_issue: observed op=%0h pc=%0h expected no issue", opcode, ins_pc);
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("issue_opcode",  32'(opcode),  32'(mon_e.op));
          chk("issue_operand", 32'(operand), 32'(mon_e.opr));
          chk("issue_pc",      32'(ins_pc),  32'(mon_e.pc));
        end
      end
    end
  end

  initial begin
    // reset state
    hold_reset();
    chk("rst_ins_valid",   32'(ins_valid),   32'h0);
    chk("rst_rom_address", 32'(rom_address), 32'h0);
    chk("rst_opcode",      32'(opcode),      32'h0);
    chk("rst_operand",     32'(operand),     32'h0);
    chk("rst_ins_pc",      32'(ins_pc),      32'h0);
    chk("rst_illegal_op",  32'(illegal_op),  32'h0);

    // 1: mixed program, BVC loop back to 04
    hold_reset();
    rom[0] = 8'h86; rom[1] = 8'h00; rom[2] = 8'h88; rom[3] = 8'h01;
    rom[4] = 8'h42; rom[5] = 8'h42; rom[6] = 8'h26; rom[7] = 8'h04;
    ins_ready = 1'b1; ex_idle = 1'b1; ccr = 4'b0000;
    push(8'h86, 8'h00, 8'h00);
    push(8'h88, 8'h01, 8'h02);
    push(8'h42, 8'h00, 8'h04);
    push(8'h42, 8'h00, 8'h05);
    push(8'h42, 8'h00, 8'h04);
    push(8'h42, 8'h00, 8'h05);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t1_first_issue_cycle", 32'(ins_valid), 32'(k == 4));
    end
    drain("t1");
    chk("t1_no_illegal", 32'(ill_cnt), 32'h0);

    // 2: BEQ at 0x20, Z=0 then Z=1
    hold_reset();
    rom[8'h00] = 8'h20; rom[8'h01] = 8'h20;
    rom[8'h20] = 8'h23; rom[8'h21] = 8'h10;
    rom[8'h22] = 8'h42;
    rom[8'h23] = 8'h20; rom[8'h24] = 8'h20;
    rom[8'h10] = 8'h43;
    rom[8'h11] = 8'h20; rom[8'h12] = 8'h11;
    ccr = 4'b0000;
    push(8'h42, 8'h00, 8'h22);
    rst = 1'b0;
    drain("t2_not_taken");
    chk("t2_nt_next_fetch", 32'(rom_address), 32'h23);
    ccr = 4'b0100;
    push(8'h43, 8'h00, 8'h10);
    drain("t2_taken");
    chk("t2_t_next_fetch", 32'(rom_address), 32'h11);

    // 3: backpressure during ISSUE of 87 55
    hold_reset();
    rom[0] = 8'h87; rom[1] = 8'h55; rom[2] = 8'h20; rom[3] = 8'h02;
    ccr = 4'b0000; ins_ready = 1'b0;
    rst = 1'b0;
    step(4);
    for (int k = 0; k < 7; k++) begin
      chk("t3_hold_valid",   32'(ins_valid), 32'h1);
      chk("t3_hold_opcode",  32'(opcode),    32'h87);
      chk("t3_hold_operand", 32'(operand),   32'h55);
      step();
    end
    push(8'h87, 8'h55, 8'h00);
    ins_ready = 1'b1;
    step();
    chk("t3_valid_dropped", 32'(ins_valid),   32'h0);
    chk("t3_next_fetch",    32'(rom_address), 32'h02);
    drain("t3");

    // 4: BVS stalled 4 cycles; ccr only counts at the first ex_idle=1 cycle
    hold_reset();
    rom[0] = 8'h25; rom[1] = 8'h06; rom[2] = 8'h42;
    rom[3] = 8'h20; rom[4] = 8'h03;
    rom[6] = 8'h43; rom[7] = 8'h20; rom[8] = 8'h07;
    ex_idle = 1'b0; ccr = 4'b0000;
    rst = 1'b0;
    step(4);
    for (int k = 0; k < 4; k++) begin
      chk("t4_stall_pc",    32'(rom_address), 32'h02);
      chk("t4_stall_valid", 32'(ins_valid),   32'h0);
      step();
    end
    ex_idle = 1'b1; ccr = 4'b0010;
    push(8'h43, 8'h00, 8'h06);
    step();
    ccr = 4'b0000;
    chk("t4_taken_fetch", 32'(rom_address), 32'h06);
    drain("t4");

    // 5a: 1-byte at 0x7F wraps to 0x00
    hold_reset();
    rom[0] = 8'h20; rom[1] = 8'h7F; rom[127] = 8'h42;
    push(8'h42, 8'h00, 8'h7F);
    rst = 1'b0;
    drain("t5_wrap1");
    chk("t5_wrap_fetch", 32'(rom_address), 32'h00);
    push(8'h42, 8'h00, 8'h7F);
    drain("t5_wrap1_again");

    // 5b/6: BRA FF -> 0x7F; 2-byte operand from 0x00; illegal FF at 0x01
    hold_reset();
    rom[0] = 8'h20; rom[1] = 8'hFF; rom[2] = 8'h20; rom[3] = 8'h02;
    rom[127] = 8'h86;
    push(8'h86, 8'h20, 8'h7F);
    push(8'hFF, 8'h00, 8'h01);
    rst = 1'b0;
    drain("t5_wrap2_illegal");
    chk("t6_illegal_pulse_cycles", 32'(ill_cnt), 32'h1);

    // 6: reset in LATCH_OPR and in ISSUE abandons the instruction
    hold_reset();
    rom[0] = 8'h86; rom[1] = 8'h33; rom[2] = 8'h20; rom[3] = 8'h02;
    ins_ready = 1'b0;
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    #1;
    chk("t6_rst_opr_valid",   32'(ins_valid),   32'h0);
    chk("t6_rst_opr_address", 32'(rom_address), 32'h00);
    chk("t6_rst_opr_opcode",  32'(opcode),      32'h00);
    rst = 1'b0;
    step(4);
    chk("t6_issue_valid", 32'(ins_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_issue_valid",   32'(ins_valid),   32'h0);
    chk("t6_rst_issue_address", 32'(rom_address), 32'h00);
    ins_ready = 1'b1;
    push(8'h86, 8'h33, 8'h00);
    rst = 1'b0;
    drain("t6_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
